// File: rtl/pd_mem_pkg.sv
// pd_mem_pkg: shared FSM/owner types and defaults for the pd memory arbiter
package pd_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
    localparam int STARVE_MAX_DEF = 3;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one memory port with starvation guard and misalign trap
module mem_arbiter
    import pd_mem_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic              dm_err_o,
    input  logic              flush_i,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    state_t            state, state_nx;
    owner_t            owner;
    logic              is_wr, is_err, flushed, rd_en, wr_en;
    logic [CW-1:0]     starve;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, if_rdata_q, dm_rdata_q;
    logic              pend, arb, fetch_win, dm_mis, starve_full, acc, resp;

    always_comb begin
        pend        = if_req_i | dm_req_i;
        arb         = (state != ACCESS) & pend;
        starve_full = starve == CW'(STARVE_MAX);
        fetch_win   = if_req_i & (~dm_req_i | starve_full);
        dm_mis      = dm_addr_i[1:0] != 2'b00;
        state_nx    = (state == ACCESS) ? RESP : (pend ? ACCESS : IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_IF;
            is_wr      <= 1'b0;
            is_err     <= 1'b0;
            rd_en      <= 1'b0;
            wr_en      <= 1'b0;
            flushed    <= 1'b0;
            starve     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (arb) begin
                owner   <= fetch_win ? OWN_IF : OWN_DM;
                addr_q  <= fetch_win ? {if_addr_i[AWIDTH-1:2], 2'b00} : dm_addr_i;
                wdata_q <= fetch_win ? '0 : dm_wdata_i;
                is_wr   <= ~fetch_win & dm_we_i;
                is_err  <= ~fetch_win & dm_mis;
                rd_en   <= fetch_win | (~dm_we_i & ~dm_mis);
                wr_en   <= ~fetch_win & dm_we_i & ~dm_mis;
            end
            flushed <= acc & flush_i;
            // counts only data wins that made a waiting fetch wait longer
            starve  <= !if_req_i ? '0 :
                       !arb      ? starve :
                       fetch_win ? '0 :
                       starve_full ? starve : starve + CW'(1);
            if (if_rvalid_o) if_rdata_q <= mem_data_i;
            if (dm_rvalid_o) dm_rdata_q <= mem_data_i;
        end
    end

    always_comb begin
        acc            = state == ACCESS;
        resp           = state == RESP;
        if_gnt_o       = acc & (owner == OWN_IF);
        dm_gnt_o       = acc & (owner == OWN_DM);
        mem_read_en_o  = acc & rd_en;
        mem_write_en_o = acc & wr_en;
        mem_addr_o     = addr_q;
        mem_data_o     = wdata_q;
        if_rvalid_o    = resp & (owner == OWN_IF) & ~flushed & ~flush_i;
        dm_rvalid_o    = resp & (owner == OWN_DM) & ~is_wr & ~is_err;
        dm_err_o       = resp & (owner == OWN_DM) & is_err;
        if_rdata_o     = if_rvalid_o ? mem_data_i : if_rdata_q;
        dm_rdata_o     = dm_rvalid_o ? mem_data_i : dm_rdata_q;
    end
endmodule
